instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving prefetch FIFO entries and the maximum in-flight fetches (2..8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port suspend_cpu, input, 1 bit: pipeline stall; while high, outputs hold and no new request is issued.
REQ-006 The block SHALL have ports branch_taken (input, 1 bit) and branch_target (input, 16 bits): a single-cycle PC redirect from the branch stage.
REQ-007 The block SHALL have ports imem_req (output, 1), imem_addr (output, 16) and imem_gnt (input, 1): the fetch request channel, with a transfer when imem_req and imem_gnt are both high.
REQ-008 The block SHALL have ports imem_rvalid (input, 1) and imem_rdata (input, 21): in-order responses, at least one cycle after the grant.
REQ-009 The block SHALL have ports instruction (output, 21), if_pc (output, 16) and instr_valid (output, 1): the registered word, its address and its valid flag, driven to decode.
REQ-010 The block SHALL have port fetch_err (output, 1): a sticky protocol-error flag.

Function
REQ-011 The FSM SHALL have two states: RUN (fetching) and FLUSH (discarding stale responses).
REQ-012 Register pc SHALL be word-addressed and drive imem_addr combinationally; it SHALL wrap from 16'hFFFF to 16'h0000.
REQ-013 imem_req SHALL be high only when all hold: state RUN, suspend_cpu=0, branch_taken=0, and outstanding+fifo_count<DEPTH.
REQ-014 A transfer (imem_req & imem_gnt) SHALL increment pc and outstanding.
REQ-015 An address FIFO SHALL record each granted pc so every response is paired with its address.
REQ-016 In RUN, each imem_rvalid SHALL decrement outstanding and push {imem_rdata, tagged pc} into the FIFO; the credit rule guarantees the FIFO never overflows.
REQ-017 When suspend_cpu=0 and the FIFO is non-empty, the block SHALL pop the head into instruction/if_pc with instr_valid=1 at the next edge.
REQ-018 When suspend_cpu=0 and the FIFO is empty, the next edge SHALL load a bubble: instruction=21'd0, if_pc=0, instr_valid=0 (ADD r0, a no-op).
REQ-019 While suspend_cpu=1, the block SHALL hold instruction, if_pc and instr_valid, pop nothing, and still accept responses into the FIFO.
REQ-020 No FIFO bypass SHALL exist: a word pushed at edge N is at the outputs no earlier than edge N+1.
REQ-021 branch_taken SHALL take priority over suspend_cpu and every other event.
REQ-022 On branch_taken the next edge SHALL set pc=branch_target, clear the FIFO and the address FIFO, and load a bubble on the outputs.
REQ-023 On branch_taken, discard_cnt SHALL be set to the in-flight count; state SHALL be FLUSH if that count is nonzero, otherwise RUN.
REQ-024 In FLUSH, each imem_rvalid SHALL decrement discard_cnt and outstanding and be dropped; when the count reaches 0, state SHALL return to RUN.
REQ-025 A branch_taken arriving during FLUSH SHALL reload pc and keep the current discard_cnt.
REQ-026 An imem_rvalid in the same cycle as branch_taken SHALL count as retired, and its data SHALL be dropped.
REQ-027 An imem_rvalid while outstanding==0 SHALL be ignored and SHALL set fetch_err, which stays set until reset.

Reset
REQ-028 rst high SHALL immediately force: pc=RESET_PC, state RUN, outstanding=0, discard_cnt=0, FIFOs empty, instruction=0, if_pc=0, instr_valid=0, fetch_err=0, imem_req=0.
REQ-029 Reset asserted mid-operation SHALL abandon all in-flight fetches without error.
REQ-030 After rst falls, the first request (addr RESET_PC) SHALL be issued in the first cycle.

Verification
REQ-031 Scenario: reset released; gnt=1; rvalid one cycle after grant; rdata=21'h00108 at addr 0 -> instruction=21'h00108, if_pc=0, instr_valid=1 in cycle 3; bubbles before that.
REQ-032 Scenario: gnt held low -> imem_req stays 1 at addr 0, pc does not advance, outputs remain bubbles.
REQ-033 Scenario: suspend_cpu=1 for 5 cycles with responses returning -> outputs frozen; FIFO fills to DEPTH and imem_req drops; after release, words emerge in address order with no loss.
REQ-034 Scenario: 2 fetches in flight, then branch_taken with target 16'h0040 -> both responses dropped; next outputs start at if_pc=16'h0040; fetch_err=0.
REQ-035 Scenario: branch_taken coincident with a grant and an rvalid -> granted and returned words never appear at the outputs; pc=target.
REQ-036 Scenario: imem_rvalid injected with nothing outstanding -> fetch_err=1 and stays set; the outputs are unaffected.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues credit-limited requests, pairs in-order responses with
// their addresses, and feeds decode from a prefetch FIFO through a registered output.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        suspend_cpu,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [20:0] imem_rdata,
  output logic [20:0] instruction,
  output logic [15:0] if_pc,
  output logic        instr_valid,
  output logic        fetch_err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;
  typedef struct packed {
    logic [20:0] word;
    logic [15:0] addr;
  } entry_t;

  state_t        state, state_nxt;
  logic [15:0]   pc;
  logic [CW-1:0] outstanding, discard_cnt, fifo_count, out_nxt, br_inflight;
  logic [PW-1:0] rd_ptr, wr_ptr, a_rd_ptr, a_wr_ptr;
  entry_t        fifo_mem [DEPTH];
  logic [15:0]   addr_mem [DEPTH];
  logic          fire, retire, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign imem_addr   = pc;
  assign fire        = imem_req & imem_gnt;
  // A response with nothing outstanding is a protocol error and retires nothing.
  assign retire      = imem_rvalid & (outstanding != '0);
  assign push        = retire & (state == RUN) & ~branch_taken;
  assign pop         = ~branch_taken & ~suspend_cpu & (fifo_count != '0);
  assign out_nxt     = outstanding + CW'(fire) - CW'(retire);
  // No request can issue alongside a branch, so in-flight is just the survivors.
  assign br_inflight = outstanding - CW'(retire);

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      RUN:   imem_req = ~rst & ~suspend_cpu & ~branch_taken &
                        (({1'b0, outstanding} + {1'b0, fifo_count}) < LIMIT);
      FLUSH: if (retire && discard_cnt == CW'(1)) state_nxt = RUN;
    endcase
    if (branch_taken) state_nxt = (br_inflight != '0) ? FLUSH : RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      a_rd_ptr    <= '0;
      a_wr_ptr    <= '0;
      instruction <= '0;
      if_pc       <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      if (imem_rvalid && outstanding == '0) fetch_err <= 1'b1;
      if (branch_taken) begin
        pc          <= branch_target;
        discard_cnt <= br_inflight;
        fifo_count  <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        a_rd_ptr    <= '0;
        a_wr_ptr    <= '0;
        instruction <= '0;
        if_pc       <= '0;
        instr_valid <= 1'b0;
      end else begin
        if (fire) begin
          pc       <= pc + 16'd1;
          a_wr_ptr <= ptr_inc(a_wr_ptr);
        end
        if (state == FLUSH && retire) discard_cnt <= discard_cnt - CW'(1);
        if (push) begin
          wr_ptr   <= ptr_inc(wr_ptr);
          a_rd_ptr <= ptr_inc(a_rd_ptr);
        end
        if (pop) begin
          rd_ptr                <= ptr_inc(rd_ptr);
          {instruction, if_pc}  <= fifo_mem[rd_ptr];
          instr_valid           <= 1'b1;
        end else if (!suspend_cpu) begin
          instruction <= '0;
          if_pc       <= '0;
          instr_valid <= 1'b0;
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: pointers and counts define what is live.
  always_ff @(posedge clk) begin
    if (fire) addr_mem[a_wr_ptr] <= pc;
    if (push) fifo_mem[wr_ptr] <= '{word: imem_rdata, addr: addr_mem[a_rd_ptr]};
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic against a
// queue-based reference model of the fetch/flush/prefetch behaviour.
module tb_instruction_fetch;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        suspend_cpu, branch_taken, imem_gnt, imem_rvalid;
  logic        imem_req, instr_valid, fetch_err;
  logic [15:0] branch_target, imem_addr, if_pc;
  logic [20:0] imem_rdata, instruction;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .suspend_cpu(suspend_cpu),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .if_pc(if_pc), .instr_valid(instr_valid),
    .fetch_err(fetch_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [20:0] word;
    logic [15:0] addr;
  } ent_t;

  // reference model
  logic [15:0] m_pc;
  logic [15:0] m_inflight [$];
  int          m_discard;
  ent_t        m_fifo [$];
  logic [20:0] m_instr;
  logic [15:0] m_ifpc;
  logic        m_valid, m_err;

  // memory responder
  logic [15:0] mem_q [$];
  logic        rv_en;
  logic        inject;

  function automatic logic [20:0] word_of(input logic [15:0] a);
    return 21'h00108 + {a, 5'b0};
  endfunction

  function automatic logic model_req();
    return !rst && m_discard == 0 && !suspend_cpu && !branch_taken &&
           (m_inflight.size() + m_discard + m_fifo.size() < DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_bubble();
    m_instr = '0;
    m_ifpc  = '0;
    m_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC;
    m_inflight.delete();
    m_fifo.delete();
    m_discard = 0;
    m_err = 1'b0;
    model_bubble();
    mem_q.delete();
  endtask

  task automatic model_step(input logic fire);
    logic retired;
    ent_t e, h;
    logic have;
    have    = 1'b0;
    retired = imem_rvalid && (m_inflight.size() + m_discard > 0);
    if (imem_rvalid && !retired) m_err = 1'b1;
    if (branch_taken) begin
      if (retired) begin
        if (m_discard > 0) m_discard--;
        else void'(m_inflight.pop_front());
      end
      m_discard += m_inflight.size();
      m_inflight.delete();
      m_fifo.delete();
      m_pc = branch_target;
      model_bubble();
    end else begin
      if (retired) begin
        if (m_discard > 0) m_discard--;
        else begin
          e.addr = m_inflight.pop_front();
          e.word = imem_rdata;
          have   = 1'b1;
        end
      end
      if (!suspend_cpu) begin
        if (m_fifo.size() > 0) begin
          h       = m_fifo.pop_front();
          m_instr = h.word;
          m_ifpc  = h.addr;
          m_valid = 1'b1;
        end else model_bubble();
      end
      if (have) m_fifo.push_back(e);
      if (fire) begin
        m_inflight.push_back(m_pc);
        m_pc = m_pc + 16'd1;
      end
    end
  endtask

  // One clock: drive the response, check request side, clock, check outputs.
  task automatic cyc();
    logic        req_m, fire;
    logic [15:0] a;
    if (inject) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 21'h1FFFFF;
    end else if (rv_en && mem_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(mem_q[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    req_m = model_req();
    chk("imem_req", 32'(imem_req), 32'(req_m));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    fire = imem_req && imem_gnt;
    a    = imem_addr;
    @(posedge clk);
    if (imem_rvalid && !inject) void'(mem_q.pop_front());
    if (fire) mem_q.push_back(a);
    model_step(req_m && imem_gnt);
    #1;
    chk("instruction", 32'(instruction), 32'(m_instr));
    chk("if_pc", 32'(if_pc), 32'(m_ifpc));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    suspend_cpu = 1'b0;
    branch_taken = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    inject = 1'b0;
    rv_en = 1'b0;
    #2;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_ifpc", 32'(if_pc), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'(RESET_PC));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_valid(input string tag, input logic [15:0] exp_pc);
    int n;
    n = 0;
    while (!instr_valid && n < 30) begin
      cyc();
      n++;
    end
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_pc"}, 32'(if_pc), 32'(exp_pc));
  endtask

  initial begin
    suspend_cpu = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    inject = 1'b0; rv_en = 1'b0;
    #1;
    do_reset();

    // first word reaches decode on the third edge
    imem_gnt = 1'b1; rv_en = 1'b1;
    cyc(); chk("s1_bubble1", 32'(instr_valid), 32'd0);
    cyc(); chk("s1_bubble2", 32'(instr_valid), 32'd0);
    cyc();
    chk("s1_instr", 32'(instruction), 32'h00108);
    chk("s1_ifpc", 32'(if_pc), 32'd0);
    chk("s1_valid", 32'(instr_valid), 32'd1);
    repeat (3) cyc();

    // reset with fetches in flight, then grant withheld
    do_reset();
    imem_gnt = 1'b0;
    repeat (4) begin
      cyc();
      chk("s2_req", 32'(imem_req), 32'd1);
      chk("s2_addr", 32'(imem_addr), 32'(RESET_PC));
      chk("s2_valid", 32'(instr_valid), 32'd0);
    end

    // credit limit, then stall while responses fill the FIFO
    imem_gnt = 1'b1; rv_en = 1'b0;
    repeat (DEPTH) cyc();
    chk("s3_credit", 32'(imem_req), 32'd0);
    suspend_cpu = 1'b1; rv_en = 1'b1;
    repeat (5) begin
      cyc();
      chk("s3_frozen", 32'(instr_valid), 32'd0);
    end
    suspend_cpu = 1'b0;
    #1;
    chk("s3_full_req", 32'(imem_req), 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      cyc();
      chk("s3_order_pc", 32'(if_pc), 32'(RESET_PC + 16'(k)));
      chk("s3_order_valid", 32'(instr_valid), 32'd1);
    end

    // branch with two fetches in flight
    do_reset();
    imem_gnt = 1'b1; rv_en = 1'b0;
    cyc(); cyc();
    imem_gnt = 1'b0; branch_taken = 1'b1; branch_target = 16'h0040;
    cyc();
    branch_taken = 1'b0;
    chk("s4_pc", 32'(imem_addr), 32'h0040);
    chk("s4_bubble", 32'(instr_valid), 32'd0);
    imem_gnt = 1'b1; rv_en = 1'b1;
    wait_valid("s4", 16'h0040);
    chk("s4_err", 32'(fetch_err), 32'd0);

    // branch coincident with grant and response
    repeat (3) cyc();
    branch_taken = 1'b1; branch_target = 16'h0080;
    cyc();
    branch_taken = 1'b0;
    chk("s5_pc", 32'(imem_addr), 32'h0080);
    chk("s5_bubble", 32'(instr_valid), 32'd0);
    wait_valid("s5", 16'h0080);

    // pc wrap
    branch_taken = 1'b1; branch_target = 16'hFFFE;
    cyc();
    branch_taken = 1'b0;
    wait_valid("wrap0", 16'hFFFE);
    cyc(); chk("wrap1_pc", 32'(if_pc), 32'hFFFF);
    cyc(); chk("wrap2_pc", 32'(if_pc), 32'h0000);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      suspend_cpu   = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 19) == 0);
      branch_target = ($urandom_range(0, 7) == 0) ? 16'hFFFD : 16'($urandom);
      imem_gnt      = ($urandom_range(0, 2) != 0);
      rv_en         = ($urandom_range(0, 2) != 0);
      cyc();
    end
    suspend_cpu = 1'b0; branch_taken = 1'b0;

    // drain, then a response with nothing outstanding
    imem_gnt = 1'b0; rv_en = 1'b1;
    repeat (DEPTH + 6) cyc();
    chk("s6_drained", 32'(mem_q.size()), 32'd0);
    inject = 1'b1;
    cyc();
    inject = 1'b0;
    chk("s6_err", 32'(fetch_err), 32'd1);
    repeat (3) cyc();
    chk("s6_sticky", 32'(fetch_err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
